c880_vec_gen: RTL and testbench
===============================

# c880_vec_gen

LFSR-based stimulus generator that produces the 60-bit input vectors for the c880 benchmark netlist. It sits directly upstream of the c880 instance and replaces file-loaded random vectors with an on-chip, seedable pseudo-random sequence. Vectors are delivered over a valid/ready handshake, so the consumer (netlist wrapper or response capture) sets the pace. After a programmed number of vectors the block stops and flags done.

## Interface
- VEC_WIDTH, 60, vector width; bit 59 drives N1, bit 0 drives N268.
- VEC_COUNT, 64, vectors per run, ≥ 2.
- SEED, 60'h000000000000001, default LFSR seed; must be nonzero.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; honoured in IDLE and DONE, ignored in RUN.
- abort  in  1  synchronous; return to IDLE from any state.
- seed_in  in  VEC_WIDTH  run seed, sampled on accepted start; zero selects SEED.
- vec_ready  in  1  consumer accepts vec this cycle.
- vec  out  VEC_WIDTH  current vector.
- vec_valid  out  1  vec is valid.
- vec_idx  out  $clog2(VEC_COUNT)  index of the current vector, 0-based.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, lfsr = SEED, vec = 0, vec_valid = 0, vec_idx = 0, busy = 0, done = 0.
- IDLE/DONE + start:
  - lfsr and vec load seed_in, or SEED if seed_in == 0.
  - vec_idx = 0, vec_valid = 1, busy = 1, done = 0; next state RUN.
- RUN:
  - Transfer occurs when vec_valid && vec_ready.
  - No transfer: vec, vec_idx and lfsr hold unchanged.
  - Transfer with vec_idx < VEC_COUNT-1: lfsr steps, vec takes the new lfsr value, vec_idx increments.
  - Transfer with vec_idx == VEC_COUNT-1: vec_valid = 0, busy = 0, done = 1; vec holds its last value; lfsr does not step; next state DONE.
- LFSR step (Fibonacci, shift left):
  - new_bit = ^(lfsr & TAP_MASK).
  - lfsr_next = {lfsr[VEC_WIDTH-2:0], new_bit}.
  - For width 60, TAP_MASK has bits 59 and 58 set (x^60+x^59+1, maximal length).
  - The all-zero state is unreachable.
- DONE holds until start or abort.
- abort in any state:
  - Next cycle: IDLE, vec_valid = 0, busy = 0, done = 0, vec_idx = 0.
  - lfsr and vec keep their values.
  - abort has priority over start and over a transfer in the same cycle.
- start during RUN has no effect.

## Timing
- start → first vec_valid: 1 cycle.
- Throughput: one vector per cycle with vec_ready held high.
- A full run with vec_ready constantly high takes VEC_COUNT cycles from first valid to the done rising edge.
- done asserts the cycle after the last transfer.
- start in DONE: done falls and vec_valid rises in the same cycle.
- Asynchronous rst mid-run returns all outputs to their reset values immediately; no partial vector is retained.
- vec is stable whenever vec_valid && !vec_ready. Consumers may sample vec on any edge while valid.

## Structure
- Package c880_tb_pkg holds:
  - C880_VEC_WIDTH = 60 and C880_OUT_WIDTH = 26.
  - TAP_MASK constant.
  - State enum gen_state_t {IDLE, RUN, DONE}.
- One sub-module, lfsr_step: a purely combinational next-state function parameterised by width and tap mask. It is reused later by the downstream response compactor (MISR).
- Top: FSM, lfsr register, index counter, output registers.

## Test plan
- Reset, then start with seed_in = 0 and vec_ready = 1:
  - vec sequence is 0x1, 0x2, 0x4, …, vec_idx 58 = 1<<58, vec_idx 59 = 0x800000000000001.
  - done rises after 64 transfers.
- Backpressure:
  - Drop vec_ready for 5 cycles at vec_idx = 3; vec stays 0x8 and vec_idx stays 3.
  - Resume; vec_idx 4 = 0x10.
- Custom seed: seed_in = 60'hFFFFFFFFFFFFFFF.
  - vec_idx 0 = all ones; vec_idx 1 = 0xFFFFFFFFFFFFFFE (new bit 1^1 = 0).
- abort at vec_idx = 10 with vec_ready = 1:
  - Next cycle vec_valid = 0, busy = 0, vec_idx = 0.
  - A following start reloads the seed.
- rst asserted mid-run, asynchronously between edges:
  - All outputs read reset values before the next clock edge.
- start pulsed in RUN is ignored. start in DONE begins a new run whose vec_idx 0 equals the seed.

Source files
------------

// File: rtl/c880_tb_pkg.sv
// c880_tb_pkg: shared widths, LFSR taps and generator state encoding for the c880 bench
package c880_tb_pkg;
  localparam int C880_VEC_WIDTH = 60;
  localparam int C880_OUT_WIDTH = 26;
  localparam logic [C880_VEC_WIDTH-1:0] TAP_MASK = 60'hC00_0000_0000_0000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one Fibonacci shift-left step of a width/tap-parameterised LFSR
module lfsr_step #(
  parameter int W = 60,
  parameter logic [W-1:0] TAPS = '1
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);
  assign nxt = {cur[W-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/c880_vec_gen.sv
// c880_vec_gen: seedable LFSR vector source for c880 with valid/ready delivery and run count
module c880_vec_gen
  import c880_tb_pkg::*;
#(
  parameter int VEC_WIDTH = C880_VEC_WIDTH,
  parameter int VEC_COUNT = 64,
  parameter logic [VEC_WIDTH-1:0] SEED = 60'h000000000000001,
  parameter logic [VEC_WIDTH-1:0] TAPS = TAP_MASK
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [VEC_WIDTH-1:0]         seed_in,
  input  logic                         vec_ready,
  output logic [VEC_WIDTH-1:0]         vec,
  output logic                         vec_valid,
  output logic [$clog2(VEC_COUNT)-1:0] vec_idx,
  output logic                         busy,
  output logic                         done
);
  localparam int IW = $clog2(VEC_COUNT);
  localparam logic [IW-1:0] LAST = IW'(VEC_COUNT - 1);
  gen_state_t state;
  logic [VEC_WIDTH-1:0] lfsr, lfsr_nxt, seed;
  assign seed = (seed_in == '0) ? SEED : seed_in;
  lfsr_step #(.W(VEC_WIDTH), .TAPS(TAPS)) u_step (.cur(lfsr), .nxt(lfsr_nxt));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      vec       <= '0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        state     <= RUN;
        lfsr      <= seed;
        vec       <= seed;
        vec_valid <= 1'b1;
        vec_idx   <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
      end
    end else if (vec_valid && vec_ready) begin
      if (vec_idx == LAST) begin
        state     <= DONE;
        vec_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        lfsr    <= lfsr_nxt;
        vec     <= lfsr_nxt;
        vec_idx <= vec_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_c880_vec_gen.sv
// tb_c880_vec_gen: directed checks of the c880 vector generator
module tb_c880_vec_gen;
  logic clk = 0, rst = 1, start = 0, abort = 0, vec_ready = 0;
  logic [59:0] seed_in = '0;
  logic [59:0] vec;
  logic vec_valid, busy, done;
  logic [5:0] vec_idx;
  int checks = 0, errors = 0;

  c880_vec_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_in(seed_in),
    .vec_ready(vec_ready), .vec(vec), .vec_valid(vec_valid), .vec_idx(vec_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [59:0] act, input logic [59:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, {59'd0, vec_valid}, 60'd0);
    chk({name, "_busy"}, {59'd0, busy}, 60'd0);
    chk({name, "_done"}, {59'd0, done}, 60'd0);
    chk({name, "_idx"}, {54'd0, vec_idx}, 60'd0);
  endtask

  task automatic do_start(input logic [59:0] s);
    seed_in = s;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    chk_idle("reset");
    chk("reset_vec", vec, 60'd0);
    rst = 0;
    tick();
    chk_idle("reset_hold");
  endtask

  task automatic test_full_run();
    logic [59:0] m;
    vec_ready = 1;
    do_start(60'd0);
    m = 60'd1;
    for (int i = 0; i < 64; i++) begin
      if (i < 59) chk("run_pow2", vec, 60'd1 << i);
      else if (i == 59) chk("run_idx59", vec, 60'h800000000000001);
      else chk("run_model", vec, m);
      chk("run_idx", {54'd0, vec_idx}, 60'(i));
      chk("run_valid", {59'd0, vec_valid & busy & ~done}, 60'd1);
      if (i < 63) m = {m[58:0], m[59] ^ m[58]};
      tick();
    end
    chk("run_done", {59'd0, done}, 60'd1);
    chk("run_end_valid", {59'd0, vec_valid}, 60'd0);
    chk("run_end_busy", {59'd0, busy}, 60'd0);
    chk("run_end_vec", vec, m);
    tick();
    chk("run_done_hold", {59'd0, done}, 60'd1);
  endtask

  task automatic test_start_in_done();
    do_start(60'h123);
    chk("sid_done", {59'd0, done}, 60'd0);
    chk("sid_valid", {59'd0, vec_valid}, 60'd1);
    chk("sid_vec", vec, 60'h123);
    chk("sid_idx", {54'd0, vec_idx}, 60'd0);
    tick();
    chk("sid_vec1", vec, 60'h246);
  endtask

  task automatic test_backpressure();
    do_abort();
    vec_ready = 1;
    do_start(60'd0);
    repeat (3) tick();
    vec_ready = 0;
    chk("bp_vec3", vec, 60'h8);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        seed_in = 60'h55;
        start = 1;
      end
      tick();
      start = 0;
      chk("bp_hold_vec", vec, 60'h8);
      chk("bp_hold_idx", {54'd0, vec_idx}, 60'd3);
      chk("bp_hold_valid", {59'd0, vec_valid}, 60'd1);
    end
    vec_ready = 1;
    tick();
    chk("bp_vec4", vec, 60'h10);
    chk("bp_idx4", {54'd0, vec_idx}, 60'd4);
  endtask

  task automatic test_abort();
    repeat (6) tick();
    chk("ab_idx10", {54'd0, vec_idx}, 60'd10);
    chk("ab_vec10", vec, 60'h400);
    do_abort();
    chk_idle("ab");
    chk("ab_vec_kept", vec, 60'h400);
    do_start(60'd0);
    chk("ab_restart_vec", vec, 60'd1);
    chk("ab_restart_idx", {54'd0, vec_idx}, 60'd0);
    chk("ab_restart_busy", {59'd0, busy}, 60'd1);
  endtask

  task automatic test_custom_seed();
    do_abort();
    vec_ready = 1;
    do_start(60'hFFFFFFFFFFFFFFF);
    chk("cs_vec0", vec, 60'hFFFFFFFFFFFFFFF);
    tick();
    chk("cs_vec1", vec, 60'hFFFFFFFFFFFFFFE);
    chk("cs_idx1", {54'd0, vec_idx}, 60'd1);
    tick();
    chk("cs_vec2", vec, 60'hFFFFFFFFFFFFFFC);
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    #2;
    rst = 1;
    #1;
    chk_idle("ar");
    chk("ar_vec", vec, 60'd0);
    #1;
    rst = 0;
    tick();
    chk_idle("ar_after");
    do_start(60'd0);
    chk("ar_restart_vec", vec, 60'd1);
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_start_in_done();
    test_backpressure();
    test_abort();
    test_custom_seed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
